mc_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencing FSM for the 54-instruction MIPS core: fetch/decode/execute/memory/writeback.

---
 rtl/mc_ctrl_fsm_pkg.sv | 38 +++
 rtl/mc_wait_timer.sv | 29 ++
 rtl/mc_ctrl_fsm.sv | 166 ++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, instruction classes, control bundle.
package mc_ctrl_fsm_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned ICLASS_W = 3;

  localparam logic [STATE_W-1:0] S_RST  = 3'd0;
  localparam logic [STATE_W-1:0] S_IF   = 3'd1;
  localparam logic [STATE_W-1:0] S_ID   = 3'd2;
  localparam logic [STATE_W-1:0] S_EX   = 3'd3;
  localparam logic [STATE_W-1:0] S_MEM  = 3'd4;
  localparam logic [STATE_W-1:0] S_WB   = 3'd5;
  localparam logic [STATE_W-1:0] S_MDW  = 3'd6;
  localparam logic [STATE_W-1:0] S_TRAP = 3'd7;

  localparam logic [ICLASS_W-1:0] IC_ALU_R  = 3'd0;
  localparam logic [ICLASS_W-1:0] IC_ALU_I  = 3'd1;
  localparam logic [ICLASS_W-1:0] IC_LOAD   = 3'd2;
  localparam logic [ICLASS_W-1:0] IC_STORE  = 3'd3;
  localparam logic [ICLASS_W-1:0] IC_BRANCH = 3'd4;
  localparam logic [ICLASS_W-1:0] IC_JUMP   = 3'd5;
  localparam logic [ICLASS_W-1:0] IC_MULDIV = 3'd6;
  localparam logic [ICLASS_W-1:0] IC_OTHER  = 3'd7;

  // Datapath control bundle driven by the sequencer each cycle
  typedef struct packed {
    logic pc_we;
    logic ir_we;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic reg_we;
    logic reg_dst_sel;
    logic wb_sel;
    logic md_start;
  } ctrl_t;

endpackage

// File: rtl/mc_wait_timer.sv
// Consecutive wait-cycle counter; expired flags the last allowed non-ack cycle of a memory wait.
module mc_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  // Holds once expired so the count never wraps while the FSM leaves the wait state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the MIPS core.
// Optional memory-wait timeout trap enabled by defining MC_CTRL_TIMEOUT_EN.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned RETIRE_W       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          iclass,
  input  logic                mem_ack,
  input  logic                md_done,
  input  logic                branch_taken,
  output logic                oPcWe,
  output logic                oIrWe,
  output logic                oMemReq,
  output logic                oMemWe,
  output logic                oAddrSel,
  output logic                oRegWe,
  output logic                oRegDstSel,
  output logic                oWbSel,
  output logic                oMdStart,
  output logic [2:0]          oState,
  output logic [RETIRE_W-1:0] oRetired,
  output logic                oTimeout
);

  logic [STATE_W-1:0]  state;
  logic [STATE_W-1:0]  state_next;
  logic [ICLASS_W-1:0] cls;
  logic                retire;
  logic                wait_expired;
  ctrl_t               ctrl;

  // State, latched instruction class and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RST;
      cls      <= IC_ALU_R;
      oRetired <= '0;
    end else begin
      state <= state_next;
      if (state == S_ID) begin
        cls <= iclass;
      end
      if (retire) begin
        oRetired <= oRetired + RETIRE_W'(1);
      end
    end
  end

  // Next state and control outputs; controls are Mealy on mem_ack / branch_taken where required
  always_comb begin
    state_next = state;
    ctrl       = '0;
    retire     = 1'b0;

    case (state)
      S_RST: state_next = S_IF;

      S_IF: begin
        ctrl.mem_req = 1'b1;
        if (mem_ack) begin
          ctrl.ir_we = 1'b1;
          ctrl.pc_we = 1'b1;
          state_next = S_ID;
        end else if (wait_expired) begin
          state_next = S_TRAP;
        end
      end

      S_ID: state_next = S_EX;

      S_EX: begin
        case (cls)
          IC_ALU_R, IC_ALU_I: state_next = S_WB;
          IC_LOAD, IC_STORE:  state_next = S_MEM;
          IC_BRANCH: begin
            ctrl.pc_we = branch_taken;
            state_next = S_IF;
          end
          IC_JUMP: begin
            ctrl.pc_we = 1'b1;
            state_next = S_IF;
          end
          IC_MULDIV: begin
            ctrl.md_start = 1'b1;
            state_next    = S_MDW;
          end
          default: state_next = S_IF;
        endcase
      end

      S_MEM: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_sel = 1'b1;
        ctrl.mem_we   = (cls == IC_STORE);
        if (mem_ack) begin
          state_next = (cls == IC_STORE) ? S_IF : S_WB;
        end else if (wait_expired) begin
          state_next = S_TRAP;
        end
      end

      S_WB: begin
        ctrl.reg_we      = 1'b1;
        ctrl.reg_dst_sel = (cls == IC_ALU_R);
        ctrl.wb_sel      = (cls == IC_LOAD);
        state_next       = S_IF;
      end

      S_MDW: begin
        if (md_done) begin
          state_next = S_IF;
        end
      end

      S_TRAP: state_next = S_TRAP;

      default: state_next = S_RST;
    endcase

    // An instruction retires whenever control returns to fetch from a completing state
    retire = (state_next == S_IF) &&
             ((state == S_EX) || (state == S_MEM) || (state == S_WB) || (state == S_MDW));
  end

`ifdef MC_CTRL_TIMEOUT_EN
  logic wait_clear;
  logic wait_count;

  assign wait_clear = (state_next != state);
  assign wait_count = ((state == S_IF) || (state == S_MEM)) && !mem_ack;

  mc_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wait_clear),
    .count   (wait_count),
    .expired (wait_expired)
  );

  assign oTimeout = (state == S_TRAP);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wait_expired       = 1'b0;
  assign oTimeout           = 1'b0;
`endif

  assign oPcWe      = ctrl.pc_we;
  assign oIrWe      = ctrl.ir_we;
  assign oMemReq    = ctrl.mem_req;
  assign oMemWe     = ctrl.mem_we;
  assign oAddrSel   = ctrl.addr_sel;
  assign oRegWe     = ctrl.reg_we;
  assign oRegDstSel = ctrl.reg_dst_sel;
  assign oWbSel     = ctrl.wb_sel;
  assign oMdStart   = ctrl.md_start;
  assign oState     = state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_mc_ctrl_fsm;
  import mc_ctrl_fsm_pkg::*;

  localparam logic [8:0] PC = 9'h100;
  localparam logic [8:0] IR = 9'h080;
  localparam logic [8:0] MR = 9'h040;
  localparam logic [8:0] MW = 9'h020;
  localparam logic [8:0] AS = 9'h010;
  localparam logic [8:0] RW = 9'h008;
  localparam logic [8:0] RD = 9'h004;
  localparam logic [8:0] WS = 9'h002;
  localparam logic [8:0] MD = 9'h001;
  localparam logic [8:0] NO = 9'h000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iclass;
  logic        mem_ack, md_done, branch_taken;
  logic        oPcWe, oIrWe, oMemReq, oMemWe, oAddrSel, oRegWe, oRegDstSel, oWbSel, oMdStart;
  logic [2:0]  oState;
  logic [31:0] oRetired;
  logic        oTimeout;
  logic [8:0]  got_o;

  typedef struct {
    logic [2:0]  st;
    logic [8:0]  o;
    logic [31:0] ret;
    logic        tmo;
    string       nm;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_ret = 32'd0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(
    .RETIRE_W       (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iclass       (iclass),
    .mem_ack      (mem_ack),
    .md_done      (md_done),
    .branch_taken (branch_taken),
    .oPcWe        (oPcWe),
    .oIrWe        (oIrWe),
    .oMemReq      (oMemReq),
    .oMemWe       (oMemWe),
    .oAddrSel     (oAddrSel),
    .oRegWe       (oRegWe),
    .oRegDstSel   (oRegDstSel),
    .oWbSel       (oWbSel),
    .oMdStart     (oMdStart),
    .oState       (oState),
    .oRetired     (oRetired),
    .oTimeout     (oTimeout)
  );

  assign got_o = {oPcWe, oIrWe, oMemReq, oMemWe, oAddrSel, oRegWe, oRegDstSel, oWbSel, oMdStart};

  // Drive one cycle of inputs and queue what the DUT must show during that cycle
  task automatic cyc(input logic rn, input logic [2:0] ic, input logic ack, input logic md,
                     input logic bt, input logic [2:0] est, input logic [8:0] eo,
                     input logic etmo, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn; iclass = ic; mem_ack = ack; md_done = md; branch_taken = bt;
    e.st = est; e.o = eo; e.ret = exp_ret; e.tmo = etmo; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic fetch(input int waits, input string nm);
    for (int i = 0; i < waits; i++) cyc(1, 3'd7, 0, 0, 0, S_IF, MR, 0, {nm, "_wait"});
    cyc(1, 3'd7, 1, 0, 0, S_IF, MR | IR | PC, 0, {nm, "_ack"});
  endtask

  task automatic decode(input logic [2:0] ic, input string nm);
    cyc(1, ic, 0, 0, 0, S_ID, NO, 0, {nm, "_id"});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (oState !== e.st || got_o !== e.o || oRetired !== e.ret || oTimeout !== e.tmo) begin
        failures++;
        $display("FAIL %s: got st=%0d ctrl=%03h ret=%0d tmo=%0b, expected st=%0d ctrl=%03h ret=%0d tmo=%0b",
                 e.nm, oState, got_o, oRetired, oTimeout, e.st, e.o, e.ret, e.tmo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; iclass = 3'd0; mem_ack = 1'b0; md_done = 1'b0; branch_taken = 1'b0;
    repeat (3) cyc(0, 3'd0, 0, 0, 0, S_RST, NO, 0, "reset");
    cyc(1, 3'd7, 0, 0, 0, S_RST, NO, 0, "rst_release");

    fetch(2, "alu_r");
    decode(IC_ALU_R, "alu_r");
    cyc(1, 3'd7, 0, 0, 0, S_EX, NO, 0, "alu_r_ex");
    cyc(1, 3'd7, 0, 0, 0, S_WB, RW | RD, 0, "alu_r_wb");
    exp_ret++;

    fetch(0, "load");
    decode(IC_LOAD, "load");
    cyc(1, 3'd7, 0, 0, 0, S_EX, NO, 0, "load_ex");
    cyc(1, 3'd7, 0, 0, 0, S_MEM, MR | AS, 0, "load_mem_wait");
    cyc(1, 3'd7, 1, 0, 0, S_MEM, MR | AS, 0, "load_mem_ack");
    cyc(1, 3'd7, 0, 0, 0, S_WB, RW | WS, 0, "load_wb");
    exp_ret++;

    fetch(0, "store");
    decode(IC_STORE, "store");
    cyc(1, 3'd7, 0, 0, 0, S_EX, NO, 0, "store_ex");
    cyc(1, 3'd7, 1, 0, 0, S_MEM, MR | MW | AS, 0, "store_mem");
    exp_ret++;

    fetch(0, "br_nt");
    decode(IC_BRANCH, "br_nt");
    cyc(1, 3'd7, 0, 0, 0, S_EX, NO, 0, "br_nt_ex");
    exp_ret++;

    fetch(0, "br_t");
    decode(IC_BRANCH, "br_t");
    cyc(1, 3'd7, 0, 0, 1, S_EX, PC, 0, "br_t_ex");
    exp_ret++;

    fetch(0, "jump");
    decode(IC_JUMP, "jump");
    cyc(1, 3'd7, 0, 0, 0, S_EX, PC, 0, "jump_ex");
    exp_ret++;

    fetch(0, "other");
    decode(IC_OTHER, "other");
    cyc(1, 3'd0, 0, 0, 0, S_EX, NO, 0, "other_ex");
    exp_ret++;

    fetch(0, "alu_i");
    decode(IC_ALU_I, "alu_i");
    cyc(1, 3'd7, 0, 0, 0, S_EX, NO, 0, "alu_i_ex");
    cyc(1, 3'd7, 0, 0, 0, S_WB, RW, 0, "alu_i_wb");
    exp_ret++;

    fetch(0, "md");
    decode(IC_MULDIV, "md");
    cyc(1, 3'd7, 0, 1, 0, S_EX, MD, 0, "md_ex_start");
    for (int i = 0; i < 9; i++) cyc(1, 3'd7, 0, 0, 0, S_MDW, NO, 0, "md_wait");
    cyc(1, 3'd7, 0, 1, 0, S_MDW, NO, 0, "md_done");
    exp_ret++;

    fetch(0, "mid");
    decode(IC_LOAD, "mid");
    cyc(1, 3'd7, 0, 0, 0, S_EX, NO, 0, "mid_ex");
    cyc(1, 3'd7, 0, 0, 0, S_MEM, MR | AS, 0, "mid_mem");
    exp_ret = 32'd0;
    cyc(0, 3'd7, 0, 0, 0, S_RST, NO, 0, "reset_mid_mem");
    cyc(0, 3'd7, 0, 0, 0, S_RST, NO, 0, "reset_hold");
    cyc(1, 3'd7, 0, 0, 0, S_RST, NO, 0, "rst_release2");

`ifdef MC_CTRL_TIMEOUT_EN
    for (int i = 0; i < 4; i++) cyc(1, 3'd7, 0, 0, 0, S_IF, MR, 0, "to_if_wait");
    for (int i = 0; i < 3; i++) cyc(1, 3'd7, 1, 0, 0, S_TRAP, NO, 1, "trap_sticky");
    cyc(0, 3'd7, 0, 0, 0, S_RST, NO, 0, "trap_reset");
    cyc(1, 3'd7, 0, 0, 0, S_RST, NO, 0, "rst_release3");
    fetch(3, "to_ack4");
    decode(IC_STORE, "to_ack4");
    cyc(1, 3'd7, 0, 0, 0, S_EX, NO, 0, "to_st_ex");
    for (int i = 0; i < 4; i++) cyc(1, 3'd7, 0, 0, 0, S_MEM, MR | MW | AS, 0, "to_mem_wait");
    cyc(1, 3'd7, 0, 0, 0, S_TRAP, NO, 1, "mem_trap");
`endif

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
